// File: rtl/id_alu_decode_stage_if.sv
// Fetch/decode/execute handshake and bundle signals for id_alu_decode_stage.
//   master : the decode stage (consumes fetch offer, drives bundle and regfile addresses)
//   slave  : the surrounding pipeline (fetch, regfile, execute, hazard/flush control)
// Signals:
//   flush, ds_stall                       pipeline control into decode
//   fs_to_ds_valid, fs_inst, fs_pc        fetch offer
//   ds_allow_in                           decode can accept this cycle
//   rf_raddr1/2, rf_rdata1/2              combinational regfile read ports
//   es_allow_in, ds_to_es_valid           execute handshake
//   ds_alu_op .. ds_inst_invalid          ALU control bundle
interface id_alu_decode_stage_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OPW  = 12;

  logic            flush;
  logic            fs_to_ds_valid;
  logic [XLEN-1:0] fs_inst;
  logic [XLEN-1:0] fs_pc;
  logic            ds_allow_in;
  logic            ds_stall;
  logic [RW-1:0]   rf_raddr1;
  logic [RW-1:0]   rf_raddr2;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;
  logic            es_allow_in;
  logic            ds_to_es_valid;
  logic [OPW-1:0]  ds_alu_op;
  logic [XLEN-1:0] ds_alu_src1;
  logic [XLEN-1:0] ds_alu_src2;
  logic [RW-1:0]   ds_dest;
  logic            ds_gr_we;
  logic [XLEN-1:0] ds_pc;
  logic            ds_inst_invalid;

  modport master (
    input  flush, fs_to_ds_valid, fs_inst, fs_pc, ds_stall,
           rf_rdata1, rf_rdata2, es_allow_in,
    output ds_allow_in, rf_raddr1, rf_raddr2, ds_to_es_valid,
           ds_alu_op, ds_alu_src1, ds_alu_src2, ds_dest, ds_gr_we,
           ds_pc, ds_inst_invalid
  );

  modport slave (
    output flush, fs_to_ds_valid, fs_inst, fs_pc, ds_stall,
           rf_rdata1, rf_rdata2, es_allow_in,
    input  ds_allow_in, rf_raddr1, rf_raddr2, ds_to_es_valid,
           ds_alu_op, ds_alu_src1, ds_alu_src2, ds_dest, ds_gr_we,
           ds_pc, ds_inst_invalid
  );
endinterface

// File: rtl/id_alu_decode_stage.sv
// LA32R integer decode stage: holds one fetched instruction in a valid/allow_in
// pipeline register and decodes it combinationally into the ALU control bundle
// (one-hot alu_op, src1, src2, dest, write enable) consumed unchanged by execute.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     id_alu_decode_stage_if.master (fetch offer, regfile reads, execute bundle)
module id_alu_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input logic                   clk,
  input logic                   resetn,
  id_alu_decode_stage_if.master bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OPW  = 12;

  // one-hot alu_op bit positions
  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_SLT  = 2;
  localparam int unsigned OP_SLTU = 3;
  localparam int unsigned OP_AND  = 4;
  localparam int unsigned OP_NOR  = 5;
  localparam int unsigned OP_OR   = 6;
  localparam int unsigned OP_XOR  = 7;
  localparam int unsigned OP_SLL  = 8;
  localparam int unsigned OP_SRL  = 9;
  localparam int unsigned OP_SRA  = 10;
  localparam int unsigned OP_LUI  = 11;

  logic            valid_r;
  logic [XLEN-1:0] inst_r;
  logic [XLEN-1:0] pc_r;

  logic ready_go;
  logic handoff;

  // pipeline handshake
  assign ready_go              = ~bus.ds_stall;
  assign handoff               = ready_go & bus.es_allow_in;
  assign bus.ds_allow_in       = ~valid_r | handoff;
  assign bus.ds_to_es_valid    = valid_r & ready_go & ~bus.flush;

  // stage register; flush wins over any capture in the same cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_r <= 1'b0;
      inst_r  <= '0;
      pc_r    <= RESET_PC;
    end else if (bus.flush) begin
      valid_r <= 1'b0;
    end else if (bus.ds_allow_in) begin
      valid_r <= bus.fs_to_ds_valid;
      if (bus.fs_to_ds_valid) begin
        inst_r <= bus.fs_inst;
        pc_r   <= bus.fs_pc;
      end
    end
  end

  // instruction fields
  logic [RW-1:0] rd;
  logic [RW-1:0] rj;
  logic [RW-1:0] rk;
  logic [16:0]   op17;
  logic [9:0]    op10;
  logic [6:0]    op7;
  logic [4:0]    ui5;
  logic [11:0]   i12;
  logic [19:0]   si20;

  assign rd   = inst_r[4:0];
  assign rj   = inst_r[9:5];
  assign rk   = inst_r[14:10];
  assign op17 = inst_r[31:15];
  assign op10 = inst_r[31:22];
  assign op7  = inst_r[31:25];
  assign ui5  = inst_r[14:10];
  assign i12  = inst_r[21:10];
  assign si20 = inst_r[24:5];

  // opcode matches; the 3R/shift, 2RI12 and 1RI20 groups never overlap
  logic is_add_w, is_sub_w, is_slt, is_sltu;
  logic is_nor, is_and, is_or, is_xor;
  logic is_slli_w, is_srli_w, is_srai_w;
  logic is_addi_w, is_slti, is_sltui;
  logic is_andi, is_ori, is_xori;
  logic is_lu12i_w;

  assign is_add_w   = (op17 == 17'h00020);
  assign is_sub_w   = (op17 == 17'h00022);
  assign is_slt     = (op17 == 17'h00024);
  assign is_sltu    = (op17 == 17'h00025);
  assign is_nor     = (op17 == 17'h00028);
  assign is_and     = (op17 == 17'h00029);
  assign is_or      = (op17 == 17'h0002a);
  assign is_xor     = (op17 == 17'h0002b);
  assign is_slli_w  = (op17 == 17'h00081);
  assign is_srli_w  = (op17 == 17'h00089);
  assign is_srai_w  = (op17 == 17'h00091);
  assign is_addi_w  = (op10 == 10'h00a);
  assign is_slti    = (op10 == 10'h008);
  assign is_sltui   = (op10 == 10'h009);
  assign is_andi    = (op10 == 10'h00d);
  assign is_ori     = (op10 == 10'h00e);
  assign is_xori    = (op10 == 10'h00f);
  assign is_lu12i_w = (op7  == 7'h0a);

  // src2 source selection
  logic sel_ui5;
  logic sel_si12;
  logic sel_ui12;
  logic sel_si20;

  assign sel_ui5  = is_slli_w | is_srli_w | is_srai_w;
  assign sel_si12 = is_addi_w | is_slti | is_sltui;
  assign sel_ui12 = is_andi | is_ori | is_xori;
  assign sel_si20 = is_lu12i_w;

  logic [OPW-1:0] alu_op;
  logic           valid_op;

  // one-hot operation; stays zero for any encoding outside the subset
  always_comb begin
    alu_op          = '0;
    alu_op[OP_ADD]  = is_add_w | is_addi_w;
    alu_op[OP_SUB]  = is_sub_w;
    alu_op[OP_SLT]  = is_slt | is_slti;
    alu_op[OP_SLTU] = is_sltu | is_sltui;
    alu_op[OP_AND]  = is_and | is_andi;
    alu_op[OP_NOR]  = is_nor;
    alu_op[OP_OR]   = is_or | is_ori;
    alu_op[OP_XOR]  = is_xor | is_xori;
    alu_op[OP_SLL]  = is_slli_w;
    alu_op[OP_SRL]  = is_srli_w;
    alu_op[OP_SRA]  = is_srai_w;
    alu_op[OP_LUI]  = is_lu12i_w;
  end

  assign valid_op = |alu_op;

  logic [XLEN-1:0] src2;

  // second operand: register rk by default, otherwise the decoded immediate
  always_comb begin
    src2 = bus.rf_rdata2;
    if (sel_ui5) begin
      src2 = XLEN'(ui5);
    end else if (sel_si12) begin
      src2 = {{(XLEN-12){i12[11]}}, i12};
    end else if (sel_ui12) begin
      src2 = XLEN'(i12);
    end else if (sel_si20) begin
      src2 = {si20, 12'b0};
    end
  end

  // bundle to execute and regfile read addresses
  assign bus.rf_raddr1       = rj;
  assign bus.rf_raddr2       = rk;
  assign bus.ds_alu_op       = alu_op;
  assign bus.ds_alu_src1     = bus.rf_rdata1;
  assign bus.ds_alu_src2     = src2;
  assign bus.ds_dest         = rd;
  assign bus.ds_gr_we        = valid_r & valid_op & (rd != '0);
  assign bus.ds_pc           = pc_r;
  assign bus.ds_inst_invalid = valid_r & ~valid_op;

endmodule

// File: tb/tb_id_alu_decode_stage.sv
// Self-checking bench for id_alu_decode_stage: fetch offers are pushed to a
// scoreboard on the fetch handshake and compared when execute takes the bundle.
module tb_id_alu_decode_stage;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  id_alu_decode_stage_if bus ();

  id_alu_decode_stage #(.RESET_PC(RESET_PC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // regfile model: r0=0, r1=5, r2=7, others 0x1000_0000+i
  function automatic logic [31:0] reg_val(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (idx == 5'd1) return 32'd5;
    if (idx == 5'd2) return 32'd7;
    return 32'h1000_0000 | 32'(idx);
  endfunction

  assign bus.rf_rdata1 = reg_val(bus.rf_raddr1);
  assign bus.rf_rdata2 = reg_val(bus.rf_raddr2);

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [11:0] op;
    logic [4:0]  dest;
    logic        we;
    logic        inv;
    logic        chk_src;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur_exp;
  exp_t        mon_e;
  int          checks   = 0;
  int          errors   = 0;
  int          consumed = 0;
  int          cyc      = 0;
  logic [31:0] next_pc  = RESET_PC + 32'h100;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [31:0] inst, input logic [11:0] op,
                              input logic [31:0] s1, input logic [31:0] s2,
                              input logic we, input logic inv, input logic chk);
    exp_t e;
    e.inst = inst; e.pc = '0; e.src1 = s1; e.src2 = s2; e.op = op;
    e.dest = inst[4:0]; e.we = we; e.inv = inv; e.chk_src = chk;
    return e;
  endfunction

  // scoreboard monitor, sampled mid-cycle while inputs are stable
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (bus.ds_to_es_valid && bus.es_allow_in) begin
        checks++;
        consumed++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: bundle pc=%h op=%h with nothing expected", bus.ds_pc, bus.ds_alu_op);
        end else begin
          mon_e = sb.pop_front();
          if ((bus.ds_alu_op !== mon_e.op) || (bus.ds_dest !== mon_e.dest) ||
              (bus.ds_gr_we !== mon_e.we) || (bus.ds_inst_invalid !== mon_e.inv) ||
              (bus.ds_pc !== mon_e.pc) ||
              (mon_e.chk_src && ((bus.ds_alu_src1 !== mon_e.src1) || (bus.ds_alu_src2 !== mon_e.src2)))) begin
            errors++;
            $display("FAIL sb_bundle inst=%h: got op=%h src1=%h src2=%h dest=%0d we=%b inv=%b pc=%h, expected op=%h src1=%h src2=%h dest=%0d we=%b inv=%b pc=%h",
                     mon_e.inst, bus.ds_alu_op, bus.ds_alu_src1, bus.ds_alu_src2, bus.ds_dest,
                     bus.ds_gr_we, bus.ds_inst_invalid, bus.ds_pc, mon_e.op, mon_e.src1, mon_e.src2,
                     mon_e.dest, mon_e.we, mon_e.inv, mon_e.pc);
          end
        end
      end
      if (bus.fs_to_ds_valid && bus.ds_allow_in && !bus.flush) sb.push_back(cur_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // offer one instruction until decode accepts it (bounded)
  task automatic offer(input exp_t e);
    exp_t x;
    logic accepted;
    x = e;
    x.pc = next_pc;
    bus.fs_inst = x.inst;
    bus.fs_pc = x.pc;
    bus.fs_to_ds_valid = 1'b1;
    cur_exp = x;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      accepted = bus.ds_allow_in && !bus.flush;
      tick();
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL offer_timeout: inst=%h not accepted, expected acceptance within 50 cycles", x.inst);
    end
    bus.fs_to_ds_valid = 1'b0;
    next_pc = next_pc + 32'd4;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.flush = 1'b0; bus.fs_to_ds_valid = 1'b0; bus.fs_inst = '0; bus.fs_pc = '0;
    bus.ds_stall = 1'b0; bus.es_allow_in = 1'b1;
    repeat (2) tick();
    checks++; if (bus.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.ds_to_es_valid); end
    checks++; if (bus.ds_allow_in !== 1'b1) begin errors++; $display("FAIL reset_allow_in: got %b expected 1", bus.ds_allow_in); end
    checks++; if (bus.ds_pc !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.ds_pc, RESET_PC); end
    checks++; if (bus.ds_inst_invalid !== 1'b0) begin errors++; $display("FAIL reset_invalid: got %b expected 0", bus.ds_inst_invalid); end
    checks++; if (bus.ds_gr_we !== 1'b0) begin errors++; $display("FAIL reset_gr_we: got %b expected 0", bus.ds_gr_we); end
    checks++; if (bus.ds_alu_op !== 12'h000) begin errors++; $display("FAIL reset_alu_op: got %h expected 000", bus.ds_alu_op); end
    @(posedge clk);
    #3 resetn = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    exp_t tbl[$];
    int c0;
    tbl.push_back(mk(32'h00100823, 12'h001, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h142468A4, 12'h800, 32'h1000_0005, 32'h1234_5000, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h03BFFC25, 12'h040, 32'd5, 32'h0000_0FFF, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h02BFFC26, 12'h001, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h00100820, 12'h001, 32'd5, 32'd7, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(32'hFFFFFFFF, 12'h000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(32'h00112507, 12'h002, 32'h1000_0008, 32'h1000_0009, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h00408C4A, 12'h100, 32'd7, 32'd3, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h0048FC2B, 12'h400, 32'd5, 32'd31, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h0044804C, 12'h200, 32'd7, 32'd0, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h0012082D, 12'h004, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h0012882E, 12'h008, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h0014082F, 12'h020, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h00148830, 12'h010, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h00150831, 12'h040, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h00158832, 12'h080, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h02200033, 12'h004, 32'd5, 32'hFFFF_F800, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h025FFC34, 12'h008, 32'd5, 32'h0000_07FF, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h03600035, 12'h010, 32'd5, 32'h0000_0800, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h03C00436, 12'h080, 32'd5, 32'd1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h00410C4A, 12'h000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(32'h15FFFFF7, 12'h800, 32'h1000_001F, 32'hFFFF_F000, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(32'h00000000, 12'h000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0));
    c0 = consumed;
    bus.es_allow_in = 1'b1;
    offer(tbl[0]);
    checks++;
    if (bus.ds_to_es_valid !== 1'b1) begin
      errors++; $display("FAIL latency: ds_to_es_valid got %b expected 1 one cycle after fetch handshake", bus.ds_to_es_valid);
    end
    for (int i = 1; i < tbl.size(); i++) offer(tbl[i]);
    repeat (3) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL decode_drain: %0d bundles left, expected 0", sb.size()); end
    checks++; if (consumed - c0 != tbl.size()) begin errors++; $display("FAIL decode_count: got %0d bundles expected %0d", consumed - c0, tbl.size()); end
  endtask

  task automatic test_back_to_back();
    int start;
    start = cyc;
    for (int i = 0; i < 8; i++)
      offer(mk(32'h00100823, 12'h001, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1));
    checks++;
    if (cyc - start != 8) begin errors++; $display("FAIL throughput: 8 instrs took %0d cycles expected 8", cyc - start); end
    repeat (2) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d bundles left, expected 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    logic [11:0] s_op;
    logic [31:0] s_src2;
    logic [31:0] s_pc;
    int          c0;
    c0 = consumed;
    bus.es_allow_in = 1'b1;
    offer(mk(32'h00100823, 12'h001, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1));
    offer(mk(32'h00112507, 12'h002, 32'h1000_0008, 32'h1000_0009, 1'b1, 1'b0, 1'b1));
    bus.es_allow_in = 1'b0;
    bus.fs_inst = 32'h03BFFC25; bus.fs_pc = next_pc; bus.fs_to_ds_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.ds_allow_in !== 1'b0) begin errors++; $display("FAIL bp_allow_in0: got %b expected 0", bus.ds_allow_in); end
    checks++; if (bus.ds_alu_op !== 12'h002) begin errors++; $display("FAIL bp_held_op: got %h expected 002", bus.ds_alu_op); end
    s_op = bus.ds_alu_op; s_src2 = bus.ds_alu_src2; s_pc = bus.ds_pc;
    tick();
    @(negedge clk);
    checks++; if (bus.ds_allow_in !== 1'b0) begin errors++; $display("FAIL bp_allow_in1: got %b expected 0", bus.ds_allow_in); end
    checks++;
    if ((bus.ds_alu_op !== s_op) || (bus.ds_alu_src2 !== s_src2) || (bus.ds_pc !== s_pc) || (bus.ds_to_es_valid !== 1'b1)) begin
      errors++; $display("FAIL bp_stable: got op=%h src2=%h pc=%h v=%b expected op=%h src2=%h pc=%h v=1",
                         bus.ds_alu_op, bus.ds_alu_src2, bus.ds_pc, bus.ds_to_es_valid, s_op, s_src2, s_pc);
    end
    tick();
    bus.es_allow_in = 1'b1;
    offer(mk(32'h03BFFC25, 12'h040, 32'd5, 32'h0000_0FFF, 1'b1, 1'b0, 1'b1));
    repeat (2) tick();
    checks++; if (consumed - c0 != 3) begin errors++; $display("FAIL bp_count: got %0d bundles expected 3", consumed - c0); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: %0d bundles left, expected 0", sb.size()); end
  endtask

  task automatic test_ds_stall();
    offer(mk(32'h0012082D, 12'h004, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1));
    bus.ds_stall = 1'b1;
    bus.fs_inst = 32'h00150831; bus.fs_pc = next_pc; bus.fs_to_ds_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (bus.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL stall_valid: got %b expected 0", bus.ds_to_es_valid); end
      checks++; if (bus.ds_allow_in !== 1'b0) begin errors++; $display("FAIL stall_allow_in: got %b expected 0", bus.ds_allow_in); end
      tick();
    end
    bus.ds_stall = 1'b0;
    offer(mk(32'h00150831, 12'h040, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1));
    repeat (2) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL stall_drain: %0d bundles left, expected 0", sb.size()); end
  endtask

  task automatic test_flush();
    logic [31:0] a_pc;
    bus.es_allow_in = 1'b0;
    a_pc = next_pc;
    offer(mk(32'h00100823, 12'h001, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1));
    bus.flush = 1'b1;
    bus.fs_inst = 32'h142468A4; bus.fs_pc = 32'hDEAD_0000; bus.fs_to_ds_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_now: got %b expected 0", bus.ds_to_es_valid); end
    tick();
    bus.flush = 1'b0; bus.fs_to_ds_valid = 1'b0; bus.es_allow_in = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    checks++; if (bus.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_next: got %b expected 0", bus.ds_to_es_valid); end
    checks++; if (bus.ds_allow_in !== 1'b1) begin errors++; $display("FAIL flush_allow_in: got %b expected 1", bus.ds_allow_in); end
    checks++; if (bus.ds_gr_we !== 1'b0) begin errors++; $display("FAIL flush_gr_we: got %b expected 0", bus.ds_gr_we); end
    checks++; if (bus.ds_pc !== a_pc) begin errors++; $display("FAIL flush_no_capture: pc got %h expected %h", bus.ds_pc, a_pc); end
    tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL flush_drain: %0d bundles left, expected 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    bus.es_allow_in = 1'b0;
    offer(mk(32'h02BFFC26, 12'h001, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1));
    @(negedge clk);
    checks++; if (bus.ds_to_es_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b expected 1", bus.ds_to_es_valid); end
    #1 resetn = 1'b0;
    #1;
    checks++; if (bus.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", bus.ds_to_es_valid); end
    checks++; if (bus.ds_pc !== RESET_PC) begin errors++; $display("FAIL rmid_pc: got %h expected %h", bus.ds_pc, RESET_PC); end
    sb.delete();
    @(posedge clk);
    #3 resetn = 1'b1;
    bus.es_allow_in = 1'b1;
    tick();
    offer(mk(32'h00408C4A, 12'h100, 32'd7, 32'd3, 1'b1, 1'b0, 1'b1));
    repeat (2) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rmid_drain: %0d bundles left, expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_ds_stall();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
